if_fetch_unit: RTL

Instruction fetch front end. It issues sequential word fetches to instruction memory over a valid/ready request channel and collects in-order responses into a small prefetch FIFO. It then presents {pc, pc+4, instr, valid} to the IF/ID pipeline register. It is the producer end of the IF/ID interface: it honours the same stall and flush (redirect) semantics that the IF/ID register applies on its side.

---
 rtl/if_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_DRAIN
  } fetch_state_e;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; push/pop allowed together even when full,
// clear empties it in one cycle.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_entry_t     push_data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[PTR_W'(i)] <= '{pc: '0, instr: INSTR_NOP};
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order prefetch
// FIFO, IF/ID producer outputs. Optional same-cycle bypass: FETCH_BYPASS_EN.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic [31:0] pc_if_o,
  output logic [31:0] pc4_if_o,
  output logic [31:0] instr_if_o,
  output logic        instr_valid_if_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;

  fetch_state_e     state;
  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] drop_new;
  logic [CNT_W-1:0] drop_nxt;
  logic [CNT_W-1:0] live_out;
  logic [CNT_W-1:0] fifo_count;
  logic [CRD_W-1:0] credit;
  logic             running;
  logic             req_fire;
  logic             resp_live;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             out_valid;
  fetch_entry_t     fifo_head;
  fetch_entry_t     resp_entry;
  fetch_entry_t     out_entry;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];
  assign redirect_target     = {redirect_pc_i[31:2], 2'b00};

  // Credit: live in-flight requests plus queued entries never exceed FIFO slots.
  assign running  = !rst && (state != S_BOOT);
  assign live_out = outstanding - drop_cnt;
  assign credit   = {1'b0, live_out} + {1'b0, fifo_count};

  assign imem_req_valid_o = running && !redirect_i
                         && (outstanding < CNT_W'(MAX_OUTSTANDING))
                         && (credit < CRD_W'(FIFO_DEPTH));
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;

  assign resp_live  = imem_resp_valid_i && !redirect_i && (drop_cnt == '0);
  assign resp_entry = '{pc: resp_pc, instr: imem_resp_data_i};
  assign drop_new   = outstanding - CNT_W'(imem_resp_valid_i);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fifo_empty && resp_live;
  assign out_entry = bypass ? resp_entry : fifo_head;
  assign out_valid = !redirect_i && (!fifo_empty || bypass);
  assign fifo_push = resp_live && !(bypass && !stall_i);
`else
  assign out_entry = fifo_head;
  assign out_valid = !redirect_i && !fifo_empty;
  assign fifo_push = resp_live;
`endif

  assign fifo_pop = out_valid && !stall_i && !fifo_empty;

  assign instr_valid_if_o = out_valid;
  assign pc_if_o          = out_valid ? out_entry.pc : '0;
  assign pc4_if_o         = out_valid ? out_entry.pc + PC_STEP : '0;
  assign instr_if_o       = out_valid ? out_entry.instr : '0;

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .pop      (fifo_pop),
    .clear    (redirect_i),
    .push_data(resp_entry),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Stale responses still in flight at a redirect are counted off here.
  always_comb begin
    drop_nxt = drop_cnt;
    if (redirect_i) begin
      drop_nxt = drop_new;
    end else if (imem_resp_valid_i && (drop_cnt != '0)) begin
      drop_nxt = drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem_resp_valid_i);
      drop_cnt    <= drop_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_STEP;
        if (resp_live) resp_pc <= resp_pc + PC_STEP;
      end
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (redirect_i && (drop_new != '0)) state <= S_DRAIN;
        S_DRAIN: if (drop_nxt == '0) state <= S_RUN;
        default: state <= S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid_i && (outstanding == '0)));
      assert (!(fifo_push && fifo_full && !fifo_pop));
    end
  end

endmodule
